// File: rtl/cond_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cond_unit_if                                                         |
// | Bundle of decode/ALU inputs and gated-enable/status outputs that     |
// | connect the conditional-execution unit to the datapath.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface cond_unit_if #(
  parameter int CNT_W = 16
);
  logic             InstrValid;
  logic             Stall;
  logic [3:0]       Cond;
  logic             S;
  logic [3:0]       ALUControl;
  logic [3:0]       ALUFlags;
  logic             RegWIn;
  logic             MemWIn;
  logic             PCSIn;
  logic             CntClear;
  logic             RegWrite;
  logic             MemWrite;
  logic             PCSrc;
  logic             CondEx;
  logic [3:0]       Flags;
  logic             carry_in;
  logic [CNT_W-1:0] ExecCount;
  logic [CNT_W-1:0] SkipCount;

  // Datapath side: drives decode and ALU results, consumes the gated enables.
  modport master (
    output InstrValid, Stall, Cond, S, ALUControl, ALUFlags,
           RegWIn, MemWIn, PCSIn, CntClear,
    input  RegWrite, MemWrite, PCSrc, CondEx, Flags, carry_in,
           ExecCount, SkipCount
  );

  // Condition unit side.
  modport slave (
    input  InstrValid, Stall, Cond, S, ALUControl, ALUFlags,
           RegWIn, MemWIn, PCSIn, CntClear,
    output RegWrite, MemWrite, PCSrc, CondEx, Flags, carry_in,
           ExecCount, SkipCount
  );
endinterface
`default_nettype wire

// File: rtl/cond_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cond_unit                                                            |
// | Holds the NZCV register, evaluates the condition field against it,   |
// | gates register/memory/PC write enables and counts executed/skipped   |
// | instructions with saturating counters.                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cond_unit #(
  parameter logic [3:0] FLAG_RESET = 4'b0000,
  parameter int         CNT_W      = 16
) (
  input  wire logic   clk,
  input  wire logic   reset_n,
  cond_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_exec_cnt;
  logic [CNT_W-1:0] r_skip_cnt;

  logic w_n, w_z, w_c, w_v;
  logic w_cond_ex;
  logic w_issue;
  logic w_commit;
  logic w_skip;
  logic w_compare;
  logic w_arith;
  logic w_flag_wr;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  // Condition decode against the stored (pre-update) flags.
  always_comb begin
    w_cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = ~w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = ~w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = ~w_v;
      4'b1000: w_cond_ex = w_c & ~w_z;
      4'b1001: w_cond_ex = ~w_c | w_z;
      4'b1010: w_cond_ex = (w_n == w_v);
      4'b1011: w_cond_ex = (w_n != w_v);
      4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ex = w_z | (w_n != w_v);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;  // reserved encoding never executes
    endcase
  end

  // Op classification: TST/TEQ/CMP/CMN occupy 10xx; arithmetic ops update V.
  always_comb begin
    w_compare = (bus.ALUControl[3:2] == 2'b10);
    w_arith   = 1'b0;
    case (bus.ALUControl)
      4'b0010, 4'b0011, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1010, 4'b1011: w_arith = 1'b1;
      default:                            w_arith = 1'b0;
    endcase
  end

  assign w_issue   = bus.InstrValid & ~bus.Stall;
  assign w_commit  = w_issue & w_cond_ex;
  assign w_skip    = w_issue & ~w_cond_ex;
  assign w_flag_wr = w_commit & (bus.S | w_compare);

  assign bus.CondEx    = w_cond_ex;
  assign bus.RegWrite  = w_commit & bus.RegWIn & ~w_compare;
  assign bus.MemWrite  = w_commit & bus.MemWIn;
  assign bus.PCSrc     = w_commit & bus.PCSIn;
  assign bus.Flags     = r_flags;
  assign bus.carry_in  = r_flags[1];
  assign bus.ExecCount = r_exec_cnt;
  assign bus.SkipCount = r_skip_cnt;

  // NZCV register; logical ops keep the previous V.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_flags <= FLAG_RESET;
    end else if (w_flag_wr) begin
      if (w_arith) begin
        r_flags <= bus.ALUFlags;
      end else begin
        r_flags <= {bus.ALUFlags[3:1], r_flags[0]};
      end
    end
  end

  // Saturating executed/skipped counters; clear beats increment.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_exec_cnt <= '0;
      r_skip_cnt <= '0;
    end else if (bus.CntClear) begin
      r_exec_cnt <= '0;
      r_skip_cnt <= '0;
    end else begin
      if (w_commit && (r_exec_cnt != c_cnt_max)) begin
        r_exec_cnt <= r_exec_cnt + c_cnt_one;
      end
      if (w_skip && (r_skip_cnt != c_cnt_max)) begin
        r_skip_cnt <= r_skip_cnt + c_cnt_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cond_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cond_unit                                                         |
// | Self-checking bench: directed vector table, randomized run against   |
// | a behavioural flag/condition model, reset-during-stall and counter   |
// | saturation sequences.                                                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cond_unit;

  logic clk;
  logic reset_n;

  int n_vec;
  int n_err;

  cond_unit_if #(.CNT_W(16)) bus ();
  cond_unit_if #(.CNT_W(4))  bus4 ();

  cond_unit #(.FLAG_RESET(4'b1010), .CNT_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  cond_unit #(.FLAG_RESET(4'b0000), .CNT_W(4)) dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus4)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v, st;
    logic [3:0] cond;
    logic       s;
    logic [3:0] op, af;
    logic       rw, mw, ps, clr;
    logic       e_regw, e_memw, e_pcs, e_cex;
    logic [3:0] e_flags;
    int         e_exec, e_skip;
  } vec_t;

  vec_t tbl[15];

  // Behavioural model state
  logic [3:0] m_flags;
  int         m_exec, m_skip;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic v, st, input logic [3:0] cond, input logic s,
    input logic [3:0] op, af, input logic rw, mw, ps, clr,
    input logic e_regw, e_memw, e_pcs, e_cex,
    input logic [3:0] e_flags, input int e_exec, e_skip);
    vec_t r;
    r.v = v; r.st = st; r.cond = cond; r.s = s; r.op = op; r.af = af;
    r.rw = rw; r.mw = mw; r.ps = ps; r.clr = clr;
    r.e_regw = e_regw; r.e_memw = e_memw; r.e_pcs = e_pcs; r.e_cex = e_cex;
    r.e_flags = e_flags; r.e_exec = e_exec; r.e_skip = e_skip;
    return r;
  endfunction

  // Condition predicate from the architectural rules: odd codes invert the
  // predicate of the even code below them; 1111 never passes.
  function automatic bit m_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return base ^ c[0];
  endfunction

  function automatic bit m_is_cmp(input logic [3:0] op);
    return (op >= 4'd8) && (op <= 4'd11);
  endfunction

  function automatic bit m_is_arith(input logic [3:0] op);
    return ((op >= 4'd2) && (op <= 4'd7)) || (op == 4'd10) || (op == 4'd11);
  endfunction

  task automatic drive(input logic v, st, input logic [3:0] cond, input logic s,
                       input logic [3:0] op, af, input logic rw, mw, ps, clr);
    bus.InstrValid = v;   bus.Stall  = st;  bus.Cond   = cond; bus.S = s;
    bus.ALUControl = op;  bus.ALUFlags = af; bus.RegWIn = rw;
    bus.MemWIn     = mw;  bus.PCSIn  = ps;  bus.CntClear = clr;
  endtask

  task automatic idle4();
    bus4.InstrValid = 1'b0; bus4.Stall = 1'b0; bus4.Cond = 4'hE; bus4.S = 1'b0;
    bus4.ALUControl = 4'h4; bus4.ALUFlags = 4'h0; bus4.RegWIn = 1'b0;
    bus4.MemWIn = 1'b0; bus4.PCSIn = 1'b0; bus4.CntClear = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 4'hE, 1'b0, 4'h4, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle4();

    // Directed table (flags reset to 1010)
    //            v  st cond   s  op     af     rw mw ps clr  regw memw pcs cex  flags  ex sk
    tbl[0]  = mk(1, 0, 4'hE, 1, 4'h2, 4'h6, 1, 0, 0, 0,  1, 0, 0, 1, 4'h6, 1, 0); // SUB S -> 0110
    tbl[1]  = mk(1, 0, 4'h0, 0, 4'h4, 4'hF, 1, 0, 0, 0,  1, 0, 0, 1, 4'h6, 2, 0); // EQ passes
    tbl[2]  = mk(1, 0, 4'h1, 0, 4'h4, 4'hF, 1, 1, 1, 0,  0, 0, 0, 0, 4'h6, 2, 1); // NE skips
    tbl[3]  = mk(1, 0, 4'hE, 0, 4'hA, 4'h1, 1, 0, 0, 0,  0, 0, 0, 1, 4'h1, 3, 1); // CMP -> 0001
    tbl[4]  = mk(1, 0, 4'hE, 1, 4'hC, 4'h8, 1, 0, 0, 0,  1, 0, 0, 1, 4'h9, 4, 1); // ORR keeps V
    tbl[5]  = mk(1, 0, 4'hE, 0, 4'hA, 4'h8, 1, 0, 0, 0,  0, 0, 0, 1, 4'h8, 5, 1); // CMP S=0
    tbl[6]  = mk(1, 0, 4'hB, 0, 4'h4, 4'h3, 1, 1, 1, 0,  1, 1, 1, 1, 4'h8, 6, 1); // LT passes
    tbl[7]  = mk(1, 1, 4'hE, 1, 4'h2, 4'h4, 1, 0, 0, 0,  0, 0, 0, 1, 4'h8, 6, 1); // stall 1
    tbl[8]  = mk(1, 1, 4'hE, 1, 4'h2, 4'h4, 1, 0, 0, 0,  0, 0, 0, 1, 4'h8, 6, 1); // stall 2
    tbl[9]  = mk(1, 1, 4'hE, 1, 4'h2, 4'h4, 1, 0, 0, 0,  0, 0, 0, 1, 4'h8, 6, 1); // stall 3
    tbl[10] = mk(1, 0, 4'hE, 1, 4'h2, 4'h4, 1, 0, 0, 0,  1, 0, 0, 1, 4'h4, 7, 1); // release
    tbl[11] = mk(0, 0, 4'hE, 1, 4'h2, 4'hF, 1, 1, 1, 0,  0, 0, 0, 1, 4'h4, 7, 1); // bubble
    tbl[12] = mk(1, 0, 4'hF, 1, 4'h2, 4'hF, 1, 0, 0, 0,  0, 0, 0, 0, 4'h4, 7, 2); // reserved
    tbl[13] = mk(1, 0, 4'h8, 1, 4'h8, 4'h2, 1, 0, 0, 0,  0, 0, 0, 0, 4'h4, 7, 3); // HI fails (C=0)
    tbl[14] = mk(1, 0, 4'hE, 0, 4'h4, 4'h0, 1, 0, 0, 1,  1, 0, 0, 1, 4'h4, 0, 0); // clear + commit

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset_flags", 32'(bus.Flags), 32'h0000000A);
    check("reset_carry_in", 32'(bus.carry_in), 32'd1);
    check("reset_exec", 32'(bus.ExecCount), 32'd0);
    check("reset_skip", 32'(bus.SkipCount), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].st, tbl[i].cond, tbl[i].s, tbl[i].op, tbl[i].af,
            tbl[i].rw, tbl[i].mw, tbl[i].ps, tbl[i].clr);
      #1;
      check($sformatf("tbl%0d_regwrite", i), 32'(bus.RegWrite), 32'(tbl[i].e_regw));
      check($sformatf("tbl%0d_memwrite", i), 32'(bus.MemWrite), 32'(tbl[i].e_memw));
      check($sformatf("tbl%0d_pcsrc", i),    32'(bus.PCSrc),    32'(tbl[i].e_pcs));
      check($sformatf("tbl%0d_condex", i),   32'(bus.CondEx),   32'(tbl[i].e_cex));
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_flags", i),    32'(bus.Flags),    32'(tbl[i].e_flags));
      check($sformatf("tbl%0d_carry", i),    32'(bus.carry_in), 32'(tbl[i].e_flags[1]));
      check($sformatf("tbl%0d_exec", i),     32'(bus.ExecCount), 32'(tbl[i].e_exec));
      check($sformatf("tbl%0d_skip", i),     32'(bus.SkipCount), 32'(tbl[i].e_skip));
      @(negedge clk);
    end

    // Randomized run against the behavioural model
    m_flags = 4'h4;
    m_exec  = 0;
    m_skip  = 0;
    for (int i = 0; i < 400; i++) begin
      logic v, st, s, rw, mw, ps, clr;
      logic [3:0] cond, op, af;
      bit pass, commit, issue;
      v    = ($urandom_range(0, 9) != 0);
      st   = ($urandom_range(0, 3) == 0);
      cond = 4'($urandom_range(0, 15));
      s    = 1'($urandom);
      op   = 4'($urandom_range(0, 15));
      af   = 4'($urandom_range(0, 15));
      rw   = 1'($urandom);
      mw   = 1'($urandom);
      ps   = 1'($urandom);
      clr  = ($urandom_range(0, 49) == 0);
      drive(v, st, cond, s, op, af, rw, mw, ps, clr);
      pass   = m_pass(cond, m_flags);
      issue  = v && !st;
      commit = issue && pass;
      #1;
      check("rnd_condex",   32'(bus.CondEx),   32'(pass));
      check("rnd_regwrite", 32'(bus.RegWrite), 32'(commit && rw && !m_is_cmp(op)));
      check("rnd_memwrite", 32'(bus.MemWrite), 32'(commit && mw));
      check("rnd_pcsrc",    32'(bus.PCSrc),    32'(commit && ps));
      if (commit && (s || m_is_cmp(op))) begin
        if (m_is_arith(op)) m_flags = af;
        else                m_flags = {af[3:1], m_flags[0]};
      end
      if (clr) begin
        m_exec = 0;
        m_skip = 0;
      end else begin
        if (commit)          m_exec = (m_exec < 65535) ? m_exec + 1 : 65535;
        if (issue && !pass)  m_skip = (m_skip < 65535) ? m_skip + 1 : 65535;
      end
      @(posedge clk);
      #1;
      check("rnd_flags", 32'(bus.Flags),     32'(m_flags));
      check("rnd_carry", 32'(bus.carry_in),  32'(m_flags[1]));
      check("rnd_exec",  32'(bus.ExecCount), 32'(m_exec));
      check("rnd_skip",  32'(bus.SkipCount), 32'(m_skip));
      @(negedge clk);
    end

    // Reset asserted while a flag-setting instruction is stalled
    drive(1'b1, 1'b1, 4'hE, 1'b1, 4'h2, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_stall_flags", 32'(bus.Flags),     32'h0000000A);
    check("rst_stall_exec",  32'(bus.ExecCount), 32'd0);
    check("rst_stall_skip",  32'(bus.SkipCount), 32'd0);
    @(negedge clk);
    // Release reset and stall in the same cycle: single commit of the SUB
    reset_n = 1'b1;
    bus.Stall = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_flags", 32'(bus.Flags),     32'h00000004);
    check("post_rst_exec",  32'(bus.ExecCount), 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'hE, 1'b0, 4'h4, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Saturation on the 4-bit counter instance
    bus4.InstrValid = 1'b1;
    bus4.Cond       = 4'hE;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("sat_exec_step", 32'(bus4.ExecCount), 32'((i + 1 > 15) ? 15 : i + 1));
      @(negedge clk);
    end
    check("sat_exec_final", 32'(bus4.ExecCount), 32'd15);
    check("sat_skip",       32'(bus4.SkipCount), 32'd0);
    bus4.CntClear = 1'b1;
    @(posedge clk);
    #1;
    check("clr_with_commit", 32'(bus4.ExecCount), 32'd0);
    @(negedge clk);
    idle4();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
